// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Control sequencer for a multicycle CPU datapath. One state per clock walks
// each instruction through fetch / decode / execute / memory / writeback, and
// every datapath control line is a Moore decode of the state register. The
// only Mealy terms are the ones qualified by the memory handshake (IRWrite,
// PCWrite in FETCH and instr_done in MEMWR).
//
// Memory handshake: MemRead or MemWrite is held high in a memory state until
// mem_ready is seen high in the same cycle. That cycle completes the access
// and the FSM advances on the following rising edge. Until then the FSM
// stalls in place with the request held steady.
//
// Undefined opcodes trap into ILLEGAL and HALT parks the machine. Both states
// are sticky until reset and issue no writes.
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high reset
//   opcode       in   6  IR[31:26], valid from DECODE onward
//   mem_ready    in   1  memory completes the current access this cycle
//   PCWrite      out  1  unconditional PC load
//   PCWriteCond  out  1  PC load gated by ALU zero in the datapath
//   IorD         out  1  memory address select, 0=PC, 1=ALUOut
//   MemRead      out  1  memory read request
//   MemWrite     out  1  memory write request
//   IRWrite      out  1  instruction register load
//   MemtoReg     out  1  register write data, 0=ALUOut, 1=MDR
//   PCSource     out  2  00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp        out  4  0000 ADD, 0001 SUB, 0010 RTYPE (funct)
//   ALUSrcB      out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   ALUSrcA      out  1  0=PC, 1=A
//   RegWrite     out  1  register file write
//   RegDst       out  1  destination select, 0=rt, 1=rd
//   state        out  4  current state code (debug / datapath observe)
//   instr_done   out  1  pulse on the final cycle of each instruction
//   illegal_op   out  1  high while in ILLEGAL
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_HALT  = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_HALT    = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t cur;

    // -----------------------------------------------------------------------
    // State register and next-state decode
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_LW || opcode == OP_SW) cur <= S_MEMADR;
                    else if (opcode == OP_RTYPE)            cur <= S_EXEC;
                    else if (opcode == OP_BEQ)              cur <= S_BRANCH;
                    else if (opcode == OP_J)                cur <= S_JUMP;
                    else if (opcode == OP_ADDI)             cur <= S_ADDIEX;
                    else if (opcode == OP_HALT)             cur <= S_HALT;
                    else                                    cur <= S_ILLEGAL;
                end
                // Only LW and SW reach MEMADR; opcode is stable in the IR.
                S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWB:  cur <= S_FETCH;
                S_MEMWR:  if (mem_ready) cur <= S_FETCH;
                S_EXEC:   cur <= S_ALUWB;
                S_ALUWB:  cur <= S_FETCH;
                S_BRANCH: cur <= S_FETCH;
                S_JUMP:   cur <= S_FETCH;
                S_ADDIEX: cur <= S_ADDIWB;
                S_ADDIWB: cur <= S_FETCH;
                S_HALT:    cur <= S_HALT;
                S_ILLEGAL: cur <= S_ILLEGAL;
                // Codes 14-15 recover to FETCH.
                default:  cur <= S_FETCH;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Raw write enables are computed here and then gated by
    // reset below so that nothing is written while reset is high.
    // -----------------------------------------------------------------------
    logic pc_write_d;
    logic pc_write_cond_d;
    logic mem_write_d;
    logic ir_write_d;
    logic reg_write_d;
    logic done_d;

    always_comb begin
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        mem_write_d     = 1'b0;
        ir_write_d      = 1'b0;
        reg_write_d     = 1'b0;
        done_d          = 1'b0;
        IorD            = 1'b0;
        MemRead         = 1'b0;
        MemtoReg        = 1'b0;
        PCSource        = PCSRC_ALU;
        ALUOp           = ALU_ADD;
        ALUSrcB         = SRCB_B;
        ALUSrcA         = 1'b0;
        RegDst          = 1'b0;
        illegal_op      = 1'b0;

        case (cur)
            S_FETCH: begin
                // PC+4 computed every cycle; PC and IR only load on the
                // cycle the instruction word actually arrives.
                MemRead    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ir_write_d = mem_ready;
                pc_write_d = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ALUSrcB = SRCB_IMMSH2;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_d = 1'b1;
                MemtoReg    = 1'b1;
                done_d      = 1'b1;
            end
            S_MEMWR: begin
                // Write request held through stalls; the instruction ends
                // on the cycle memory accepts it.
                mem_write_d = 1'b1;
                IorD        = 1'b1;
                done_d      = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RTYPE;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                RegDst      = 1'b1;
                done_d      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA         = 1'b1;
                ALUOp           = ALU_SUB;
                pc_write_cond_d = 1'b1;
                PCSource        = PCSRC_ALUOUT;
                done_d          = 1'b1;
            end
            S_JUMP: begin
                pc_write_d = 1'b1;
                PCSource   = PCSRC_JUMP;
                done_d     = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write_d = 1'b1;
                done_d      = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
                // HALT and unused codes: everything idle.
            end
        endcase
    end

    // Reset clears the state register asynchronously, but mem_ready could
    // still assert FETCH's enables; mask every write path directly.
    assign PCWrite     = pc_write_d      & ~reset;
    assign PCWriteCond = pc_write_cond_d & ~reset;
    assign MemWrite    = mem_write_d     & ~reset;
    assign IRWrite     = ir_write_d      & ~reset;
    assign RegWrite    = reg_write_d     & ~reset;
    assign instr_done  = done_d          & ~reset;

    assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// Testbench for multicycle_ctrl_fsm. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. Each cycle's observation is
// packed as {state, control lines, instr_done, illegal_op} and compared with
// a hand-written expected word.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUSrcB;
    logic [3:0] ALUOp;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .state       (state),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    // Control word order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    // PCSource[1:0] ALUOp[3:0] ALUSrcB[1:0] ALUSrcA RegWrite RegDst
    logic [17:0] ctrl;
    logic [23:0] obs;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};
    assign obs  = {state, ctrl, instr_done, illegal_op};

    localparam logic [17:0] C_FETCH_R = 18'b1001010_00_0000_01_000;
    localparam logic [17:0] C_FETCH_N = 18'b0001000_00_0000_01_000;
    localparam logic [17:0] C_DECODE  = 18'b0000000_00_0000_11_000;
    localparam logic [17:0] C_MEMADR  = 18'b0000000_00_0000_10_100;
    localparam logic [17:0] C_MEMRD   = 18'b0011000_00_0000_00_000;
    localparam logic [17:0] C_MEMWB   = 18'b0000001_00_0000_00_010;
    localparam logic [17:0] C_MEMWR   = 18'b0010100_00_0000_00_000;
    localparam logic [17:0] C_EXEC    = 18'b0000000_00_0010_00_100;
    localparam logic [17:0] C_ALUWB   = 18'b0000000_00_0000_00_011;
    localparam logic [17:0] C_BRANCH  = 18'b0100000_01_0001_00_100;
    localparam logic [17:0] C_JUMP    = 18'b1000000_10_0000_00_000;
    localparam logic [17:0] C_ADDIWB  = 18'b0000000_00_0000_00_010;
    localparam logic [17:0] C_IDLE    = 18'b0;

    // Step word: {mem_ready to drive, expected observation}.
    function automatic logic [24:0] v(input logic mr, input logic [3:0] st,
                                      input logic [17:0] c, input logic dn,
                                      input logic il);
        return {mr, st, c, dn, il};
    endfunction

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: hold reset for n cycles, release 1 ns after a rising edge.
    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== {4'd0, C_FETCH_N, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h want %h", i, obs, {4'd0, C_FETCH_N, 2'b00});
            end
            @(posedge clk);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_rtype();
        logic [24:0] seq [5];
        seq = '{v(1, 0, C_FETCH_R, 0, 0), v(1, 1, C_DECODE, 0, 0), v(1, 6, C_EXEC, 0, 0),
                v(1, 7, C_ALUWB, 1, 0), v(1, 0, C_FETCH_R, 0, 0)};
        opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = seq[i][24];
            @(negedge clk);
            checks++;
            if (obs !== seq[i][23:0]) begin
                errors++;
                $display("FAIL rtype cyc %0d: got %h want %h", i, obs, seq[i][23:0]);
            end
            @(posedge clk); #1;
        end
        // Back in FETCH after 4 cycles (sampled, not advanced).
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, C_FETCH_N, 2'b00}) begin
            errors++;
            $display("FAIL rtype_return: got %h want %h", obs, {4'd0, C_FETCH_N, 2'b00});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw_stall();
        logic [24:0] seq [10];
        seq = '{v(0, 0, C_FETCH_N, 0, 0), v(0, 0, C_FETCH_N, 0, 0), v(1, 0, C_FETCH_R, 0, 0),
                v(1, 1, C_DECODE, 0, 0), v(1, 2, C_MEMADR, 0, 0), v(0, 3, C_MEMRD, 0, 0),
                v(0, 3, C_MEMRD, 0, 0), v(0, 3, C_MEMRD, 0, 0), v(1, 3, C_MEMRD, 0, 0),
                v(0, 4, C_MEMWB, 1, 0)};
        opcode = 6'b100011;
        for (int i = 0; i < 10; i++) begin
            mem_ready = seq[i][24];
            @(negedge clk);
            checks++;
            if (obs !== seq[i][23:0]) begin
                errors++;
                $display("FAIL lw cyc %0d: got %h want %h", i, obs, seq[i][23:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        logic [24:0] seq [7];
        seq = '{v(1, 0, C_FETCH_R, 0, 0), v(0, 1, C_DECODE, 0, 0), v(1, 2, C_MEMADR, 0, 0),
                v(0, 5, C_MEMWR, 0, 0), v(0, 5, C_MEMWR, 0, 0), v(1, 5, C_MEMWR, 1, 0),
                v(0, 0, C_FETCH_N, 0, 0)};
        opcode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = seq[i][24];
            @(negedge clk);
            checks++;
            if (obs !== seq[i][23:0]) begin
                errors++;
                $display("FAIL sw cyc %0d: got %h want %h", i, obs, seq[i][23:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        // BEQ then J, three cycles each, with ADDI afterwards.
        logic [24:0] seq [10];
        logic [5:0]  ops [10];
        seq = '{v(1, 0, C_FETCH_R, 0, 0), v(1, 1, C_DECODE, 0, 0), v(1, 8, C_BRANCH, 1, 0),
                v(1, 0, C_FETCH_R, 0, 0), v(1, 1, C_DECODE, 0, 0), v(1, 9, C_JUMP, 1, 0),
                v(1, 0, C_FETCH_R, 0, 0), v(1, 1, C_DECODE, 0, 0), v(1, 10, C_MEMADR, 0, 0),
                v(1, 11, C_ADDIWB, 1, 0)};
        ops = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010,
                6'b001000, 6'b001000, 6'b001000, 6'b001000};
        for (int i = 0; i < 10; i++) begin
            mem_ready = seq[i][24];
            opcode    = ops[i];
            @(negedge clk);
            checks++;
            if (obs !== seq[i][23:0]) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %h want %h", i, obs, seq[i][23:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    // Trap into a sticky state, hold 20 cycles with no writes, then reset.
    task automatic test_trap(input logic [5:0] op, input logic [3:0] st, input logic il,
                             input string name);
        opcode = op;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, C_FETCH_R, 2'b00}) begin
            errors++;
            $display("FAIL %s fetch: got %h want %h", name, obs, {4'd0, C_FETCH_R, 2'b00});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs !== {st, C_IDLE, 1'b0, il}) begin
                errors++;
                $display("FAIL %s hold cyc %0d: got %h want %h", name, i, obs, {st, C_IDLE, 1'b0, il});
            end
            @(posedge clk); #1;
        end
        apply_reset(2);
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, C_FETCH_R, 2'b00}) begin
            errors++;
            $display("FAIL %s after reset: got %h want %h", name, obs, {4'd0, C_FETCH_R, 2'b00});
        end
        @(posedge clk); #1;
        // Finish this instruction cleanly as an R-type so the next test starts in FETCH.
        opcode = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);   // FETCH, DECODE, MEMADR
        #1 mem_ready = 1'b0;         // now in MEMWR, stalled
        #2;
        checks++;
        if (MemWrite !== 1'b1 || state !== 4'd5) begin
            errors++;
            $display("FAIL async pre: got MemWrite=%b state=%0d want 1/5", MemWrite, state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {4'd0, C_FETCH_N, 2'b00}) begin
            errors++;
            $display("FAIL async drop: got %h want %h", obs, {4'd0, C_FETCH_N, 2'b00});
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, C_FETCH_R, 2'b00}) begin
            errors++;
            $display("FAIL async release: got %h want %h", obs, {4'd0, C_FETCH_R, 2'b00});
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_stall();
        test_back_to_back();
        test_trap(6'b010001, 4'd13, 1'b1, "illegal");
        test_trap(6'b111111, 4'd12, 1'b0, "halt");
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
